// File: rtl/rv_fwd_unit.sv
// Execute-stage operand forwarding with a retired-write history and a load-use stall request.
// Operand outputs are combinational (0 cycles); the history shifts only on unstalled edges; stall cycles are counted, saturating.
module rv_fwd_unit #(
    parameter int XLEN       = 32,
    parameter int NREAD      = 2,
    parameter int HIST_DEPTH = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_stall,
    input  logic [NREAD*5-1:0]    i_rs,
    input  logic [NREAD-1:0]      i_rs_used,
    input  logic [NREAD*XLEN-1:0] i_reg_data,
    input  logic [4:0]            i_alu2_rd,
    input  logic                  i_alu2_reg_write,
    input  logic                  i_alu2_is_load,
    input  logic [XLEN-1:0]       i_alu2_data,
    input  logic [4:0]            i_write_rd,
    input  logic                  i_write_reg_write,
    input  logic [XLEN-1:0]       i_write_data,
    output logic [NREAD*XLEN-1:0] o_data,
    output logic [NREAD*3-1:0]    o_fwd_src,
    output logic                  o_hazard_stall,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    typedef struct packed {
        logic            vld;
        logic [4:0]      rd;
        logic [XLEN-1:0] dat;
    } hist_t;

    hist_t            hist_q [HIST_DEPTH];
    logic [NREAD-1:0] stall_vec;
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int j = 0; j < HIST_DEPTH; j++) begin
                hist_q[j] <= '0;
            end
        end else if (!i_stall) begin
            hist_q[0] <= '{vld: i_write_reg_write, rd: i_write_rd, dat: i_write_data};
            for (int j = 1; j < HIST_DEPTH; j++) begin
                hist_q[j] <= hist_q[j-1];
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_op
        logic [4:0]      rs;
        logic            alu2_hit;
        logic [XLEN-1:0] sel_dat;
        logic [2:0]      sel_src;

        assign rs       = i_rs[5*k +: 5];
        assign alu2_hit = i_alu2_reg_write && (rs != 5'd0) && (i_alu2_rd == rs);

        // Walk from oldest to youngest producer so the youngest match overrides.
        always_comb begin
            sel_dat = i_reg_data[k*XLEN +: XLEN];
            sel_src = 3'd0;
            if (rs != 5'd0) begin
                for (int j = HIST_DEPTH - 1; j >= 0; j--) begin
                    if (hist_q[j].vld && (hist_q[j].rd == rs)) begin
                        sel_dat = hist_q[j].dat;
                        sel_src = 3'(3 + j);
                    end
                end
                if (i_write_reg_write && (i_write_rd == rs)) begin
                    sel_dat = i_write_data;
                    sel_src = 3'd2;
                end
                if (alu2_hit) begin
                    sel_dat = i_alu2_data;
                    sel_src = 3'd1;
                end
            end
        end

        assign o_data[k*XLEN +: XLEN] = sel_dat;
        assign o_fwd_src[k*3 +: 3]    = sel_src;
        assign stall_vec[k]           = i_rs_used[k] & alu2_hit & i_alu2_is_load;
    end

    assign o_hazard_stall = |stall_vec;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            stall_cnt_q <= '0;
        end else if (o_hazard_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt_q;

endmodule
